// File: rtl/seq_bus_multiplier.sv
// Sequential shift-add multiplier sharing one bidirectional bus for operands and result.
// Signed mode multiplies magnitudes and negates the 2*WIDTH-bit product when the signs differ.
module seq_bus_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  inout  wire  [WIDTH-1:0] databus,
  output logic             busy,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_MULT,
    S_OUT_MSB,
    S_OUT_LSB,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_signed;
  logic                 r_neg;

  logic                 w_last;
  logic [WIDTH-1:0]     w_mag;
  logic                 w_bus_neg;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_step;

  // NOTE: state registers use non-blocking assignments and an async reset; next-state logic is
  // combinational with a default first so no latch is inferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD_A;
      S_LOAD_A:  w_next = S_LOAD_B;
      S_LOAD_B:  w_next = S_MULT;
      S_MULT:    if (w_last) w_next = S_OUT_MSB;
      S_OUT_MSB: w_next = S_OUT_LSB;
      S_OUT_LSB: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Operand magnitude straight off the bus; -2^(W-1) maps to 2^(W-1), which fits unsigned.
  always_comb begin
    w_bus_neg = r_signed & databus[WIDTH-1];
    w_mag     = w_bus_neg ? (~databus + {{(WIDTH-1){1'b0}}, 1'b1}) : databus;
    w_last    = (r_cnt == LAST_CNT);
    w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_a : {WIDTH{1'b0}})};
    w_step    = {w_sum, r_prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_prod   <= '0;
      r_signed <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_signed <= signed_op;
        S_LOAD_A: begin
          r_a   <= w_mag;
          r_neg <= w_bus_neg;
        end
        S_LOAD_B: begin
          r_prod <= {{WIDTH{1'b0}}, w_mag};
          r_neg  <= r_neg ^ w_bus_neg;
          r_cnt  <= '0;
        end
        S_MULT: begin
          r_cnt <= r_cnt + 1'b1;
          // Sign correction folds into the last iteration so OUT_MSB sees the final value.
          if (w_last && r_neg) r_prod <= ~w_step + {{(2*WIDTH-1){1'b0}}, 1'b1};
          else                 r_prod <= w_step;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign msb_out = (r_state == S_OUT_MSB);
  assign lsb_out = (r_state == S_OUT_LSB);
  assign done    = (r_state == S_DONE);

  assign databus = msb_out ? r_prod[2*WIDTH-1:WIDTH] :
                   lsb_out ? r_prod[WIDTH-1:0]       : {WIDTH{1'bz}};

endmodule

// File: tb/tb_seq_bus_multiplier.sv
// Scoreboard bench for seq_bus_multiplier: 8-bit and 16-bit instances, directed plus random
// operations, mid-operation reset, and start pulses while busy.
`timescale 1ns/1ps
module tb_seq_bus_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start8 = 1'b0, sop8 = 1'b0, start16 = 1'b0, sop16 = 1'b0;
  logic drv8_en = 1'b0, drv16_en = 1'b0;
  logic [7:0]  drv8_val = '0;
  logic [15:0] drv16_val = '0;
  wire  [7:0]  bus8;
  wire  [15:0] bus16;
  logic busy8, msb8, lsb8, done8, busy16, msb16, lsb16, done16;

  assign bus8  = drv8_en  ? drv8_val  : 8'hzz;
  assign bus16 = drv16_en ? drv16_val : 16'hzzzz;

  always #5 clk = ~clk;

  seq_bus_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(sop8), .databus(bus8),
    .busy(busy8), .msb_out(msb8), .lsb_out(lsb8), .done(done8)
  );

  seq_bus_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_op(sop16), .databus(bus16),
    .busy(busy16), .msb_out(msb16), .lsb_out(lsb16), .done(done16)
  );

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer product of the (optionally sign-interpreted) operands, truncated to 2W bits.
  function automatic logic [63:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input int w, input bit s);
    longint sa, sb, p;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(64'(a) & mask);
    sb = longint'(64'(b) & mask);
    if (s && sa[w-1]) sa = sa - (longint'(1) << w);
    if (s && sb[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  // Monitor: compares every presented product half against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (msb8) begin
        if (q8.size() == 0) check("msb8_unexpected", 64'(q8.size()), 64'd1);
        else                check("msb8_half", 64'(bus8), 64'(q8[0].hi));
      end
      if (lsb8) begin
        if (q8.size() == 0) check("lsb8_unexpected", 64'(q8.size()), 64'd1);
        else begin
          check("lsb8_half", 64'(bus8), 64'(q8[0].lo));
          void'(q8.pop_front());
        end
      end
      if (msb16) begin
        if (q16.size() == 0) check("msb16_unexpected", 64'(q16.size()), 64'd1);
        else                 check("msb16_half", 64'(bus16), 64'(q16[0].hi));
      end
      if (lsb16) begin
        if (q16.size() == 0) check("lsb16_unexpected", 64'(q16.size()), 64'd1);
        else begin
          check("lsb16_half", 64'(bus16), 64'(q16[0].lo));
          void'(q16.pop_front());
        end
      end
    end
  end

  task automatic set_start(input int sel, input logic st, input logic so);
    if (sel != 0) begin start16 = st; sop16 = so; end
    else          begin start8  = st; sop8  = so; end
  endtask

  task automatic drive(input int sel, input logic en, input logic [15:0] v);
    if (sel != 0) begin drv16_en = en; drv16_val = v; end
    else          begin drv8_en  = en; drv8_val  = v[7:0]; end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy16 : busy8;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel != 0) ? done16 : done8;
  endfunction

  // One full operation; checks busy/done cycle by cycle from the start edge k to k+W+5.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input bit s, input bit inject);
    int          w;
    logic [63:0] p;
    exp_t        e;
    w = (sel != 0) ? 16 : 8;
    p = ref_prod(a, b, w, s);
    e.hi = 16'(p >> w);
    e.lo = 16'(p & ((64'd1 << w) - 64'd1));
    @(negedge clk);
    set_start(sel, 1'b1, s);
    if (sel != 0) q16.push_back(e);
    else          q8.push_back(e);
    for (int i = 0; i <= w + 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("busy_w%0d_c%0d", w, i), 64'(get_busy(sel)), 64'(i <= w + 4));
      check($sformatf("done_w%0d_c%0d", w, i), 64'(get_done(sel)), 64'(i == w + 4));
      if (i == 0) begin
        set_start(sel, 1'b0, ~s);
        drive(sel, 1'b1, a);
      end else if (i == 1) begin
        drive(sel, 1'b1, b);
      end else if (i == 2) begin
        drive(sel, 1'b0, '0);
      end else if (inject && i == 4) begin
        set_start(sel, 1'b1, ~s);
        drive(sel, 1'b1, ~a);
      end else if (inject && i == 5) begin
        set_start(sel, 1'b0, s);
        drive(sel, 1'b0, '0);
      end
    end
  endtask

  // Starts an 8-bit 0xFF*0xFF operation and asserts reset after edge k+at.
  task automatic reset_during(input int at);
    mon_en = 1'b0;
    @(negedge clk);
    set_start(0, 1'b1, 1'b0);
    for (int i = 0; i <= at; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin set_start(0, 1'b0, 1'b0); drive(0, 1'b1, 16'h00FF); end
      else if (i == 1) drive(0, 1'b1, 16'h00FF);
      else if (i == 2) drive(0, 1'b0, '0);
    end
    check($sformatf("pre_reset_busy_%0d", at), 64'(busy8), 64'd1);
    check($sformatf("pre_reset_msb_%0d", at), 64'(msb8), 64'(at == 10));
    #2 rst_n = 1'b0;
    drive(0, 1'b1, 16'h005A);
    #1;
    check("rst_async_busy", 64'(busy8), 64'd0);
    check("rst_async_msb", 64'(msb8), 64'd0);
    check("rst_async_lsb", 64'(lsb8), 64'd0);
    check("rst_async_done", 64'(done8), 64'd0);
    check("rst_bus_released", 64'(bus8), 64'h5A);
    @(negedge clk);
    drive(0, 1'b0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    #12;
    check("reset_busy8", 64'(busy8), 64'd0);
    check("reset_done8", 64'(done8), 64'd0);
    check("reset_msb8", 64'(msb8), 64'd0);
    check("reset_lsb8", 64'(lsb8), 64'd0);
    check("reset_busy16", 64'(busy16), 64'd0);
    check("reset_msb16", 64'(msb16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'h0F, 16'h0B, 1'b0, 1'b0);
    run_op(0, 16'hFF, 16'hFF, 1'b0, 1'b0);
    run_op(0, 16'hFF, 16'h02, 1'b1, 1'b0);
    run_op(0, 16'h80, 16'h80, 1'b1, 1'b0);
    run_op(0, 16'h80, 16'h7F, 1'b1, 1'b0);
    run_op(0, 16'hFF, 16'h02, 1'b0, 1'b0);
    run_op(0, 16'h00, 16'h5A, 1'b1, 1'b0);
    run_op(0, 16'hA5, 16'h00, 1'b1, 1'b0);
    run_op(0, 16'h0F, 16'h0B, 1'b0, 1'b1);
    run_op(0, 16'h03, 16'h05, 1'b0, 1'b0);

    reset_during(5);
    run_op(0, 16'h07, 16'h06, 1'b0, 1'b0);
    reset_during(10);
    run_op(0, 16'h07, 16'h06, 1'b0, 1'b0);

    run_op(1, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++)
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 12; n++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));

    @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q16_drained", 64'(q16.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_bus_multiplier.md
Name: seq_bus_multiplier

Overview:
- Parametrised shift-add multiplier that shares one bidirectional WIDTH-bit data bus for operand input and result output.
- Sequence: after `start`, it samples operand A and then operand B from the bus. It computes the 2*WIDTH-bit product in WIDTH iterations, drives the MSB half and then the LSB half back onto the bus, then pulses `done`.
- Successor to the fixed 8-bit unsigned bus multiplier: adds width parametrisation, a per-operation signed mode, busy indication and asynchronous reset.

Parameters:
WIDTH, 8, operand width and bus width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
signed_op  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with start
databus  inout  WIDTH  shared bus; operands in, product halves out; high-Z unless driving
busy  output  1  high in every state except IDLE
msb_out  output  1  high while product[2W-1:W] is driven on databus
lsb_out  output  1  high while product[W-1:0] is driven on databus
done  output  1  one-cycle pulse after the LSB half has been presented

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy, msb_out, lsb_out, done = 0.
  - databus released to high-Z immediately, not at the next clock.
  - Operand, product and counter registers cleared.
- Outputs are Moore-decoded from the state register only; there is no combinational path from any input to any output.
- States: IDLE, LOAD_A, LOAD_B, MULT, OUT_MSB, OUT_LSB, DONE.
- IDLE: start=1 at rising edge k -> LOAD_A; signed_op latched at edge k.
- LOAD_A: edge k+1 latches databus into A -> LOAD_B.
- LOAD_B: edge k+2 latches databus into B -> MULT; iteration counter cleared.
- MULT:
  - One shift-add iteration per edge, edges k+3 .. k+2+WIDTH; exactly WIDTH iterations, no early termination.
  - After the final iteration -> OUT_MSB.
- OUT_MSB (cycle after edge k+2+WIDTH): msb_out=1, databus = product[2W-1:W]. Next edge -> OUT_LSB.
- OUT_LSB: lsb_out=1, databus = product[W-1:0]. Next edge -> DONE.
- DONE: done=1, databus high-Z. Next edge -> IDLE.
- Latency: done is high during the cycle following edge k+4+WIDTH (WIDTH=8: edge k+12). Fixed for all operand values.
- Back-to-back: a new start is accepted at the edge that leaves DONE for IDLE only if start is high on the following edge. Minimum spacing between accepted starts is WIDTH+6 cycles.
- start while busy=1: ignored, with no effect on state or registers. signed_op is ignored outside the start edge.
- Unsigned mode: product = A*B, zero-extended operands, 2*WIDTH-bit exact result.
- Signed mode:
  - Multiply the magnitudes |A| and |B| as unsigned WIDTH-bit values. Note |-2^(W-1)| = 2^(W-1) fits unsigned.
  - Negate the 2*WIDTH-bit product (two's complement) if sign(A) xor sign(B).
  - Correction is applied before entering OUT_MSB.
  - Product is always exact; no overflow is possible in either mode.
- Zero operand: full WIDTH iterations still run; product = 0 in both modes, with no negative zero.
- Bus contention rule: the block drives databus only in OUT_MSB and OUT_LSB. External drivers must release by the edge entering OUT_MSB.
- Reset mid-operation (any state): aborts the operation; the next start begins a clean sequence with no stale operands.

Test Plan:
- WIDTH=8, unsigned, A=0x0F, B=0x0B:
  - msb_out cycle shows 0x00 on databus; lsb_out cycle shows 0xA5.
  - done high exactly in the cycle after edge k+12; busy high from edge k to edge k+13.
- WIDTH=8, unsigned, A=0xFF, B=0xFF -> 0xFE then 0x01 on the bus.
- WIDTH=8, signed:
  - A=0xFF, B=0x02 -> 0xFF, 0xFE.
  - A=0x80, B=0x80 -> 0x40, 0x00.
  - A=0x80, B=0x7F -> 0xC0, 0x80.
  - Same A=0xFF, B=0x02 unsigned -> 0x01, 0xFE.
- start pulsed again during MULT with different bus data:
  - Ignored; result of the first operation is unchanged.
  - A start accepted after DONE->IDLE produces a correct second product (0x03*0x05 -> 0x00, 0x0F).
- rst_n asserted low mid-MULT and mid-OUT_MSB:
  - databus goes high-Z and all outputs drop to 0 asynchronously, before the next clock edge.
  - After release, a fresh operation 0x07*0x06 -> 0x00, 0x2A.
- WIDTH=16 regression: signed 0x8000*0xFFFF -> 0x0000, 0x8000; unsigned 0xFFFF*0xFFFF -> 0xFFFE, 0x0001; done at edge k+20.
